// File: rtl/uart_rx_os16_pkg.sv
// rtl/uart_rx_os16_pkg.sv - shared types and helpers for the oversampling UART receiver
//
// Purpose: FSM state codes, frame width and small helpers used by the receiver and its
// tick generator.
// Ports: none (package).
package uart_rx_os16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int DATA_BITS = 8;

  // Centre tick of a bit cell; samples are taken at centre-1, centre, centre+1.
  function automatic int mid_idx(input int oversample);
    return oversample / 2;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tickgen.sv
// rtl/uart_os_tickgen.sv - oversample tick divider with synchronous restart
//
// Purpose: free-running divider producing a one-clk tick every DIV clocks,
// DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE) truncated.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   restart  in  zero the divider this clk (aligns ticks to a start edge)
//   tick     out one-clk pulse on divider wrap
module uart_os_tickgen
  import uart_rx_os16_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 24000,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_os_tickgen: clock too slow for BAUD_RATE*OVERSAMPLE (DIV < 1)");
    end
  endgenerate

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With DIV=1 this is a constant 1: every clock is a tick.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// rtl/uart_rx_os16.sv - oversampling UART receiver with valid/ready byte output
//
// Purpose: receives 1 start, 8 data (LSB first), optional even parity, 1 stop bit;
// each bit is the majority of three samples around the bit centre.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   rx           serial line, idle high, asynchronous to clk
//   data_out     received byte, stable while rx_valid
//   rx_valid     byte available, held until rx_valid & rx_ready on a clk edge
//   rx_ready     consumer accepts
//   parity_err   qualifies data_out (0 when PARITY_EN=0)
//   frame_err    qualifies data_out: stop bit sampled low
//   overrun      sticky: a frame was dropped because rx_valid was still high
//   busy         receiver not idle
module uart_rx_os16
  import uart_rx_os16_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 24000,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int H  = mid_idx(OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_SMP0 = SW'(H - 1);
  localparam logic [SW-1:0] S_SMP1 = SW'(H);
  localparam logic [SW-1:0] S_DEC  = SW'(H + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  generate
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
      $error("uart_rx_os16: OVERSAMPLE must be even and >= 8");
    end
  endgenerate

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [SW-1:0]        s;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 smp0;
  logic                 smp1;
  logic                 perr;

  logic tick;
  logic restart;
  logic maj;
  logic decide;
  logic wrap;
  logic commit;
  logic handshake;

  // Two-flop synchroniser; idle-high reset so a reset does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Restarting the divider on the start edge puts tick 0 one clk after detection,
  // so the sample points are placed relative to the edge rather than a free phase.
  assign restart = (state == ST_IDLE) && !rx_s;

  uart_os_tickgen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tickgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  // Third sample is the live rx_s at the decision tick.
  assign maj       = maj3(smp0, smp1, rx_s);
  assign decide    = tick && (s == S_DEC);
  assign wrap      = tick && (s == S_LAST);
  assign commit    = (state == ST_STOP) && decide;
  assign handshake = rx_valid && rx_ready;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      s       <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      smp0    <= 1'b1;
      smp1    <= 1'b1;
      perr    <= 1'b0;
    end else begin
      if (tick && (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})) begin
        s <= (s == S_LAST) ? '0 : s + 1'b1;
        if (s == S_SMP0) smp0 <= rx_s;
        if (s == S_SMP1) smp1 <= rx_s;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            s     <= '0;
            perr  <= 1'b0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (decide && maj) begin
            state <= ST_IDLE;
          end else if (wrap) begin
            bit_idx <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (wrap) begin
            if (bit_idx == LAST_BIT) begin
              state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (decide) perr <= (^shreg) ^ maj;
          if (wrap) state <= ST_STOP;
        end
        ST_STOP: begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          if (decide) state <= maj ? ST_IDLE : ST_BREAK;
        end
        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      if (!rx_valid || handshake) begin
        data_out   <= shreg;
        parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
        frame_err  <= !maj;
        rx_valid   <= 1'b1;
        if (handshake) overrun <= 1'b0;
      end else begin
        // Consumer still holds the previous byte: drop the new one.
        overrun <= 1'b1;
      end
    end else if (handshake) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb/tb_uart_rx_os16.sv - scoreboard bench for uart_rx_os16
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       perr_a, perr_b;
  logic       ferr_a, ferr_b;
  logic       ovr_a, ovr_b;
  logic       busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  uart_rx_os16 #(
    .CLK_FREQ(384000), .BAUD_RATE(24000), .OVERSAMPLE(16), .PARITY_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .data_out(data_a), .rx_valid(valid_a),
    .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a),
    .busy(busy_a)
  );

  uart_rx_os16 #(
    .CLK_FREQ(384000), .BAUD_RATE(24000), .OVERSAMPLE(16), .PARITY_EN(0)
  ) dut_np (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .data_out(data_b), .rx_valid(valid_b),
    .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b),
    .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_a(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe;
    q_a.push_back(e);
  endtask

  task automatic exp_b(input logic [7:0] d);
    exp_t e;
    e.d = d; e.pe = 1'b0; e.fe = 1'b0;
    q_b.push_back(e);
  endtask

  task automatic drv(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  // One frame; gbit >= 0 puts a 10-unit inverted pulse 90 units into that bit cell.
  task automatic send_frame(input int sel, input logic [7:0] b, input bit par_en,
                            input bit par_inv, input bit stop_v, input int bit_t,
                            input int gbit);
    logic [10:0] fr;
    int          n;
    logic        v;
    if (par_en) begin
      fr = {stop_v, (^b) ^ par_inv, b, 1'b0};
      n  = 11;
    end else begin
      fr = {1'b1, stop_v, b, 1'b0};
      n  = 10;
    end
    for (int i = 0; i < n; i++) begin
      v  = fr[0];
      fr = fr >> 1;
      if (i == gbit) begin
        drv(sel, v); #90; drv(sel, ~v); #10; drv(sel, v); #(bit_t - 100);
      end else begin
        drv(sel, v); #(bit_t);
      end
    end
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (((q_a.size() != 0) || (q_b.size() != 0)) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drain", 32'(q_a.size() + q_b.size()), 32'd0);
  endtask

  // Monitor for the parity-enabled receiver.
  initial begin
    bit   low_next = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (low_next) begin
        chk("valid_drop_a", 32'(valid_a), 32'd0);
        low_next = 1'b0;
      end
      if (valid_a && ready_a) begin
        if (q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte_a: got %02h expected none", data_a);
        end else begin
          e = q_a.pop_front();
          chk("data_a", 32'(data_a), 32'(e.d));
          chk("perr_a", 32'(perr_a), 32'(e.pe));
          chk("ferr_a", 32'(ferr_a), 32'(e.fe));
        end
        low_next = 1'b1;
      end
    end
  end

  // Monitor for the no-parity receiver.
  initial begin
    bit   low_next = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (low_next) begin
        chk("valid_drop_b", 32'(valid_b), 32'd0);
        low_next = 1'b0;
      end
      if (valid_b && ready_b) begin
        if (q_b.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte_b: got %02h expected none", data_b);
        end else begin
          e = q_b.pop_front();
          chk("data_b", 32'(data_b), 32'(e.d));
          chk("perr_b", 32'(perr_b), 32'(e.pe));
          chk("ferr_b", 32'(ferr_b), 32'(e.fe));
          chk("ovr_b", 32'(ovr_b), 32'd0);
        end
        low_next = 1'b1;
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_perr", 32'(perr_a), 32'd0);
    chk("rst_ferr", 32'(ferr_a), 32'd0);
    chk("rst_ovr", 32'(ovr_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean frame.
    exp_a(8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    send_frame(0, 8'hA5, 1, 0, 1, 160, -1);
    wait_empty(40);
    chk("t1_ovr", 32'(ovr_a), 32'd0);

    // Bad parity, then bad stop bit with the line held low.
    exp_a(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    send_frame(0, 8'h3C, 1, 1, 1, 160, -1);
    exp_a(8'h00, 1'b0, 1'b1);
    send_frame(0, 8'h00, 1, 0, 0, 160, -1);
    repeat (40) @(negedge clk);
    chk("break_busy", 32'(busy_a), 32'd1);
    drv(0, 1'b1);
    repeat (5) @(negedge clk);
    chk("break_release", 32'(busy_a), 32'd0);
    wait_empty(20);

    // Short low pulse: rejected as a false start.
    @(negedge clk);
    drv(0, 1'b0); #30; drv(0, 1'b1);
    repeat (16) @(negedge clk);
    chk("glitch_idle", 32'(busy_a), 32'd0);
    chk("glitch_no_byte", 32'(valid_a), 32'd0);

    // Single-sample glitch at the centre of D3 is outvoted.
    exp_a(8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    send_frame(0, 8'hFF, 1, 0, 1, 160, 4);
    wait_empty(40);

    // Overrun: consumer stalled across two back-to-back frames.
    @(posedge clk); #1 ready_a = 1'b0;
    exp_a(8'h11, 1'b0, 1'b0);
    @(negedge clk);
    send_frame(0, 8'h11, 1, 0, 1, 160, -1);
    send_frame(0, 8'h22, 1, 0, 1, 160, -1);
    repeat (10) @(negedge clk);
    chk("ovr_valid", 32'(valid_a), 32'd1);
    chk("ovr_data", 32'(data_a), 32'h11);
    chk("ovr_set", 32'(ovr_a), 32'd1);
    @(posedge clk); #1 ready_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovr_valid_clr", 32'(valid_a), 32'd0);
    chk("ovr_clr", 32'(ovr_a), 32'd0);
    chk("ovr_q", 32'(q_a.size()), 32'd0);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    fork
      send_frame(0, 8'h5A, 1, 0, 1, 160, -1);
      begin
        repeat (60) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(data_a), 32'd0);
        chk("arst_valid", 32'(valid_a), 32'd0);
        chk("arst_perr", 32'(perr_a), 32'd0);
        chk("arst_ferr", 32'(ferr_a), 32'd0);
        chk("arst_ovr", 32'(ovr_a), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);
      end
    join
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_a(8'h96, 1'b0, 1'b0);
    send_frame(0, 8'h96, 1, 0, 1, 160, -1);
    wait_empty(40);

    // No-parity stream at nominal and +3 % sender baud.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      for (int i = 0; i < 150; i++) begin
        b = 8'($urandom);
        exp_b(b);
        send_frame(1, b, 0, 0, 1, (pass == 0) ? 160 : 155, -1);
      end
      wait_empty(200);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
